// File: rtl/wide_add_sequencer.sv
// Sequential N-nibble two's-complement adder reusing one 4-bit ripple slice.
// Define WIDE_ADD_SUB_EN to add the sub port and a-b support.
module wide_add_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
`ifdef WIDE_ADD_SUB_EN
   input  logic                   sub,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   carryout,
   output logic                   overflow,
   output logic                   busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            carryout_q, carryout_d;
   logic            overflow_q, overflow_d;

   logic            cin;
   logic [W-1:0]    b_in;
   logic [3:0]      nib_a;
   logic [3:0]      nib_b;
   logic [4:0]      slice;
   logic            c3;
   logic            last;

`ifdef WIDE_ADD_SUB_EN
   assign cin  = sub;
   assign b_in = sub ? ~b : b;
`else
   assign cin  = 1'b0;
   assign b_in = b;
`endif

   // One 4-bit slice per cycle; the operand nibble is picked by the index.
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int n = 0; n < NIBBLES; n++) begin
         if (idx_q == IW'(n)) begin
            nib_a = a_q[4*n +: 4];
            nib_b = b_q[4*n +: 4];
         end
      end
      slice = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
      c3    = nib_a[3] ^ nib_b[3] ^ slice[3];
      last  = (idx_q == IW'(NIBBLES - 1));
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      idx_d      = idx_q;
      carry_d    = carry_q;
      sum_d      = sum_q;
      carryout_d = carryout_q;
      overflow_d = overflow_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = a;
               b_d        = b_in;
               idx_d      = '0;
               carry_d    = cin;
               sum_d      = '0;
               carryout_d = 1'b0;
               overflow_d = 1'b0;
               state_d    = ADD;
            end
         end
         ADD: begin
            for (int n = 0; n < NIBBLES; n++) begin
               if (idx_q == IW'(n)) begin
                  sum_d[4*n +: 4] = slice[3:0];
               end
            end
            carry_d = slice[4];
            idx_d   = idx_q + IW'(1);
            if (last) begin
               carryout_d = slice[4];
               overflow_d = c3 ^ slice[4];
               idx_d      = '0;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         sum_q      <= '0;
         carryout_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         idx_q      <= idx_d;
         carry_q    <= carry_d;
         sum_q      <= sum_d;
         carryout_q <= carryout_d;
         overflow_q <= overflow_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign carryout  = carryout_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer (N=4 main instance, N=1 side instance).
// Subtraction cases run only when WIDE_ADD_SUB_EN is defined.
module tb_wide_add_sequencer;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
`ifdef WIDE_ADD_SUB_EN
   logic           sub = 1'b0;
   logic           u_sub = 1'b0;
`endif
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [W-1:0]   sum;
   logic           carryout;
   logic           overflow;
   logic           busy;

   logic           u_in_valid = 1'b0;
   logic           u_in_ready;
   logic [3:0]     u_a = '0;
   logic [3:0]     u_b = '0;
   logic           u_out_valid;
   logic           u_out_ready = 1'b1;
   logic [3:0]     u_sum;
   logic           u_carryout;
   logic           u_overflow;
   logic           u_busy;

   int checks = 0;
   int errors = 0;
   logic [W+1:0] exp_q[$];

   always #5 clk = ~clk;

   wide_add_sequencer #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
`ifdef WIDE_ADD_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .carryout(carryout), .overflow(overflow),
      .busy(busy)
   );

   wide_add_sequencer #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(u_in_valid), .in_ready(u_in_ready),
      .a(u_a), .b(u_b),
`ifdef WIDE_ADD_SUB_EN
      .sub(u_sub),
`endif
      .out_valid(u_out_valid), .out_ready(u_out_ready),
      .sum(u_sum), .carryout(u_carryout), .overflow(u_overflow),
      .busy(u_busy)
   );

   // Reference: plain wide arithmetic plus the signed-overflow sign rule.
   function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic s);
      logic [W-1:0] bp;
      logic [W:0]   t;
      logic         ov;
      bp = s ? ~y : y;
      t  = {1'b0, x} + {1'b0, bp} + {{W{1'b0}}, s};
      ov = (x[W-1] == bp[W-1]) && (t[W-1] != x[W-1]);
      return {t[W-1:0], t[W], ov};
   endfunction

   task automatic chk(input string nm, input logic [W+1:0] act,
                      input logic [W+1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out actual=%h required=none",
                     {sum, carryout, overflow});
         end else begin
            chk("result", {sum, carryout, overflow}, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic ts, input int stall);
      int g;
      int lat;
      int bc;
      logic s_eff;
      logic [W-1:0] held;
      g = 0;
      while (!in_ready && g < 50) begin
         step();
         g++;
      end
      chk("in_ready_wait", W'(g < 50), W'(1));
`ifdef WIDE_ADD_SUB_EN
      sub   = ts;
      s_eff = ts;
`else
      s_eff = 1'b0;
      if (ts) $display("note: sub request ignored without WIDE_ADD_SUB_EN");
`endif
      a         = ta;
      b         = tb;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      exp_q.push_back(model(ta, tb, s_eff));
      step();
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
`ifdef WIDE_ADD_SUB_EN
      sub      = 1'($urandom);
`endif
      lat = 0;
      bc  = 0;
      while (!out_valid && lat < 50) begin
         if (busy) bc++;
         step();
         lat++;
      end
      chk("latency", W'(lat), W'(N));
      if (busy) bc++;
      held = sum;
      for (int i = 0; i < stall; i++) begin
         chk("stall_in_ready", W'(in_ready), W'(0));
         chk("stall_valid", W'(out_valid), W'(1));
         chk("stall_sum", sum, held);
         in_valid = 1'b1;
         a        = W'($urandom);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("done_valid", W'(out_valid), W'(1));
      step();
      if (stall == 0) chk("busy_cycles", W'(bc), W'(N + 1));
      chk("post_valid", W'(out_valid), W'(0));
      chk("post_busy", W'(busy), W'(0));
      chk("post_in_ready", W'(in_ready), W'(1));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_result", {sum, carryout, overflow}, '0);
      rst_n = 1'b1;
      step();
      chk("rst_in_ready", W'(in_ready), W'(1));

      send(16'h0000, 16'h0000, 1'b0, 0);
      send(16'hFFFF, 16'h0001, 1'b0, 0);
      send(16'h7FFF, 16'h0001, 1'b0, 0);
      send(16'h8000, 16'h8000, 1'b0, 0);
      send(16'h1234, 16'h4321, 1'b0, 6);

      // Reset during the second ADD cycle discards the partial result.
      a        = 16'h00FF;
      b        = 16'h0001;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk("abort_result", {sum, carryout, overflow}, '0);
      chk("abort_valid", W'(out_valid), W'(0));
      chk("abort_busy", W'(busy), W'(0));
      step();
      rst_n = 1'b1;
      for (int i = 0; i < N + 3; i++) begin
         chk("abort_no_valid", W'(out_valid), W'(0));
         step();
      end
      send(16'h0002, 16'h0003, 1'b0, 0);

`ifdef WIDE_ADD_SUB_EN
      send(16'h0005, 16'h0007, 1'b1, 0);
      send(16'h8000, 16'h0001, 1'b1, 0);
`endif

      for (int i = 0; i < 40; i++) begin
         send(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      u_a        = 4'h7;
      u_b        = 4'h1;
      u_in_valid = 1'b1;
      step();
      u_in_valid = 1'b0;
      chk("n1_add_valid", W'(u_out_valid), W'(0));
      step();
      chk("n1_valid", W'(u_out_valid), W'(1));
      chk("n1_result", {12'h000, u_sum, u_carryout, u_overflow},
          {12'h000, 4'h8, 1'b0, 1'b1});
      step();
      chk("n1_post", W'(u_out_valid), W'(0));

      repeat (2) step();
      chk("queue_empty", W'(exp_q.size()), W'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle controller that performs N-nibble two's-complement addition by stepping one 4-bit ripple-add slice through the operands, least-significant nibble first. The carry is held in a register between nibbles. Operands arrive and results leave over valid/ready handshakes. It sits between an operand source (register file or test driver) and any consumer of wide sums, reusing the 4-bit adder datapath instead of instantiating a full-width adder.

## Interface
Parameters:
- NIBBLES, default 4: number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range is 1..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand source has a, b (and sub) valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A, two's complement.
- b  input  W  operand B, two's complement.
- sub  input  1  1 selects a-b; present only with WIDE_ADD_SUB_EN.
- out_valid  output  1  sum, carryout and overflow are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  result, low W bits.
- carryout  output  1  carry out of bit W-1.
- overflow  output  1  signed overflow: carry into bit W-1 XOR carry out of bit W-1.
- busy  output  1  high in ADD or DONE.

## Operation
- States: IDLE, ADD, DONE. Encoding is free; all outputs are registered or decoded from state only.
- IDLE: in_ready=1. When in_valid&&in_ready at an edge:
  - latch a, b (and sub);
  - clear the nibble index to 0;
  - load the carry register with cin (0, or sub with the macro);
  - go to ADD.
- ADD: in_ready=0. Each edge:
  - compute slice i = A[4i+3:4i] + B'[4i+3:4i] + carry (B' = b, or ~b when subtracting);
  - write sum[4i+3:4i];
  - update the carry register; increment the index.
  - On the edge processing i=NIBBLES-1: capture carryout and overflow, then go to DONE.
- DONE: out_valid=1; sum, carryout and overflow are held stable. On out_valid&&out_ready, go to IDLE.
- in_ready stays 0 in DONE and on the handshake edge. A new accept happens no earlier than the cycle after return to IDLE.
- Arithmetic: the result equals (a + b' + cin) mod 2^W. carryout is bit W of the unbounded sum. Overflow uses the carries of the top slice's bit 3.
- Operand inputs are ignored outside IDLE. Changing a/b while busy has no effect.
- Reset values (asserted or mid-operation): state IDLE, in_ready=1 once reset releases, out_valid=0, busy=0, sum=0, carryout=0, overflow=0, carry register 0, index 0. A partial result is discarded; no out_valid pulse follows.
- NIBBLES=1: ADD lasts exactly one cycle.

## Timing
- Accept edge T0. Nibbles are computed on edges T1..TN (N=NIBBLES). out_valid is high after edge TN, i.e. latency is N cycles from accept to out_valid.
- Minimum issue interval is N+2 cycles: accept, N ADD cycles, one DONE cycle with out_ready=1, then one IDLE cycle.
- Backpressure: DONE persists for any number of cycles while out_ready=0, with outputs unchanged.
- Simultaneous events:
  - in_valid while in DONE is ignored until IDLE.
  - rst_n assertion overrides any handshake in the same cycle.
- The combinational path per cycle is one 4-bit ripple slice only, never W bits.

## Configuration
- WIDE_ADD_SUB_EN defined:
  - the sub port exists;
  - when sub=1 at accept, B' = ~b and the initial carry is 1, so the block computes a-b;
  - carryout=1 means no borrow;
  - overflow follows the same top-slice carry rule.
- Undefined: no sub port; the initial carry is always 0; addition only.

## Test plan
- Reset, then 0x0000+0x0000 (N=4) -> out_valid exactly 4 cycles after accept; sum=0x0000, carryout=0, overflow=0; busy high for 5 cycles with out_ready=1.
- 0xFFFF+0x0001 -> sum=0x0000, carryout=1, overflow=0. Then 0x7FFF+0x0001 -> sum=0x8000, carryout=0, overflow=1. Then 0x8000+0x8000 -> sum=0x0000, carryout=1, overflow=1.
- 0x1234+0x4321 with out_ready low for 6 cycles -> sum=0x5555 held stable; in_ready=0 throughout; in_valid pulses during the stall are not accepted; completes on the first out_ready cycle.
- Assert rst_n low at the second ADD cycle of 0x00FF+0x0001 -> outputs are immediately 0, no out_valid; the next transaction 0x0002+0x0003 -> 0x0005.
- With WIDE_ADD_SUB_EN:
  - sub=1, 0x0005-0x0007 -> 0xFFFE, carryout=0, overflow=0;
  - sub=1, 0x8000-0x0001 -> 0x7FFF, carryout=1, overflow=1.
- NIBBLES=1: 0x7+0x1 -> sum=0x8, carryout=0, overflow=1, out_valid 1 cycle after accept.
